cam_cfg_sequencer: RTL and testbench
====================================

Name: cam_cfg_sequencer

Overview:
- Upstream feeder of the SCCB master. Walks an external register ROM of {reg_addr, reg_data} words and issues one SCCB write per entry using the master's start/ready handshake.
- Supports end-of-table and millisecond-delay pseudo-entries, which are needed for the camera soft reset.
- Sits between top-level camera init control and the SCCB master. Raises done when the table is exhausted.

Parameters:
- CLK_FREQ, 25000000: clk frequency in Hz. One ms equals CLK_FREQ/1000 cycles (integer division).
- ROM_AW, 8: ROM address width. Table holds at most 2**ROM_AW entries.
- WD_CYCLES, 1000000: watchdog limit per SCCB transaction, in cycles. Used only with CFG_WATCHDOG_EN.

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- cfg_start  in  1  one-cycle pulse; starts the walk from entry 0
- rom_addr  out  ROM_AW  ROM read address
- rom_data  in  16  ROM word: [15:8]=reg addr, [7:0]=reg data; valid 1 cycle after rom_addr (registered ROM)
- sccb_start  out  1  one-cycle write request to the SCCB master
- sccb_address  out  8  register address; held stable while the master is busy
- sccb_data  out  8  register data; held stable while the master is busy
- sccb_ready  in  1  master idle flag; drops 1 cycle after start is sampled, returns high when the transaction ends
- busy  out  1  high from accepted cfg_start until done
- done  out  1  sticky; high after the table completes, cleared by the next cfg_start or by rst
- err  out  1  sticky watchdog flag; 0 when CFG_WATCHDOG_EN is undefined

Behaviour:
- Reset, synchronous, checked every edge and overriding everything. Sets state=IDLE, rom_addr=0, sccb_start=0, sccb_address=0, sccb_data=0, busy=0, done=0, err=0, delay counter=0.
- Reset mid-walk aborts immediately. Any in-flight SCCB transaction is left to finish in the master. After reset, no request is issued until sccb_ready=1.
- All outputs are registered.
- IDLE: on cfg_start=1, go to FETCH with rom_addr=0, busy=1, done=0, err=0. cfg_start is ignored in every other state.
- FETCH: one wait cycle for ROM latency, then go to DECODE.
- DECODE, evaluated on rom_data:
  - 16'hFFFF: end of table; go to FINISH.
  - [15:8]=8'hFF and [7:0]=N with N<8'hFF: delay entry. N=0 is a no-op and goes to NEXT. Otherwise load the counter with N*(CLK_FREQ/1000)-1 and go to DELAY.
  - Anything else: a write. Latch sccb_address/sccb_data and go to ISSUE.
- ISSUE: wait for sccb_ready=1, then assert sccb_start=1 for exactly one cycle and go to WAIT_LOW.
- WAIT_LOW: wait for sccb_ready=0, normally the very next cycle, then go to WAIT_HIGH.
- WAIT_HIGH: wait for sccb_ready=1, then go to NEXT.
- DELAY: decrement each cycle; at 0 go to NEXT. Total DELAY residency is exactly N*(CLK_FREQ/1000) cycles.
- NEXT:
  - If rom_addr == 2**ROM_AW-1, go to FINISH. This is the implicit end; rom_addr does not wrap.
  - Otherwise increment rom_addr and go to FETCH.
- FINISH: busy=0, done=1, then IDLE.
- Latency per write entry: 2 cycles (FETCH, DECODE) + ISSUE wait + master duration + 1 (NEXT).
- Empty table (entry 0 = FFFF): done rises 3 cycles after cfg_start is sampled, and sccb_start never pulses.
- sccb_start never asserts while sccb_ready=0, and never on two consecutive cycles.

Optional Feature:
- Macro: CFG_WATCHDOG_EN.
- Defined: a counter is cleared on entry to WAIT_LOW and counts through WAIT_LOW and WAIT_HIGH. If it reaches WD_CYCLES, set err=1, busy=0, done=1 and go to IDLE, skipping the remaining entries.
- Undefined: no counter is built, err is tied to 0, and waits are unbounded.

Test Plan:
- ROM {1280, 1100, FFFF} with a behavioural SCCB model (ready low for 50 cycles): exactly two sccb_start pulses, with address/data 12/80 then 11/00; done=1 and busy=0 after the second ready rise; rom_addr stops at 2.
- CLK_FREQ=10000, ROM {FF03, 3A04, FFFF}: 30 cycles spent in DELAY before ISSUE; sccb_start carries 3A/04.
- ROM entry 0 = FFFF: done rises 3 cycles after cfg_start; zero sccb_start pulses.
- ROM_AW=2 with ROM {0101, 0202, 0303, 0404} and no FFFF: four writes, then done; rom_addr stays at 3.
- rst asserted during WAIT_HIGH of entry 1, with sccb_ready held low 20 more cycles, then cfg_start: all outputs 0 the cycle after rst; the first new sccb_start only after sccb_ready=1; the walk restarts at entry 0.
- With CFG_WATCHDOG_EN, WD_CYCLES=100, sccb_ready stuck low after start: err=1 and done=1 at 100 cycles; cfg_start pulses while busy are ignored.

Source files
------------

// File: rtl/cam_cfg_sequencer.sv
// Camera register-table sequencer: walks a {reg_addr, reg_data} ROM and feeds one SCCB write per entry.
// Optional build macro CFG_WATCHDOG_EN adds a per-transaction watchdog that drives err.
module cam_cfg_sequencer #(
  parameter int CLK_FREQ  = 25000000,
  parameter int ROM_AW    = 8,
  parameter int WD_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_start,
  output logic [7:0]        sccb_address,
  output logic [7:0]        sccb_data,
  input  logic              sccb_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int MS_CYCLES = CLK_FREQ / 1000;
  localparam int DLY_MAX   = 254 * MS_CYCLES;
  localparam int DW        = (DLY_MAX > 2) ? $clog2(DLY_MAX) : 1;
  localparam logic [ROM_AW-1:0] ADDR_LAST = {ROM_AW{1'b1}};

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_ISSUE     = 4'd3,
    ST_WAIT_LOW  = 4'd4,
    ST_WAIT_HIGH = 4'd5,
    ST_DELAY     = 4'd6,
    ST_NEXT      = 4'd7,
    ST_FINISH    = 4'd8
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [ROM_AW-1:0] rom_addr_r, rom_addr_nxt_s;
  logic              sccb_start_r, sccb_start_nxt_s;
  logic [7:0]        sccb_address_r, sccb_address_nxt_s;
  logic [7:0]        sccb_data_r, sccb_data_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              done_r, done_nxt_s;
  logic              err_r, err_nxt_s;
  logic [DW-1:0]     dly_r, dly_nxt_s;
  logic              wd_hit_s;

`ifdef CFG_WATCHDOG_EN
  localparam int WW = (WD_CYCLES > 2) ? $clog2(WD_CYCLES) : 1;
  logic [WW-1:0] wd_r;

  // Watchdog counter: zero on entry to WAIT_LOW, counts through both wait states
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_r <= {WW{1'b0}};
    end else if (state_r == ST_ISSUE) begin
      wd_r <= {WW{1'b0}};
    end else if ((state_r == ST_WAIT_LOW) || (state_r == ST_WAIT_HIGH)) begin
      wd_r <= wd_r + {{(WW-1){1'b0}}, 1'b1};
    end else begin
      wd_r <= wd_r;
    end
  end

  assign wd_hit_s = ((state_r == ST_WAIT_LOW) || (state_r == ST_WAIT_HIGH)) &&
                    (wd_r == WW'(WD_CYCLES - 1));
`else
  assign wd_hit_s = 1'b0;
`endif

  // Next-state and next-output logic for the table walk
  always_comb begin
    state_nxt_s        = state_r;
    rom_addr_nxt_s     = rom_addr_r;
    sccb_start_nxt_s   = 1'b0;
    sccb_address_nxt_s = sccb_address_r;
    sccb_data_nxt_s    = sccb_data_r;
    busy_nxt_s         = busy_r;
    done_nxt_s         = done_r;
    err_nxt_s          = err_r;
    dly_nxt_s          = dly_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_start) begin
          state_nxt_s    = ST_FETCH;
          rom_addr_nxt_s = {ROM_AW{1'b0}};
          busy_nxt_s     = 1'b1;
          done_nxt_s     = 1'b0;
          err_nxt_s      = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_nxt_s = ST_DECODE;
      end
      ST_DECODE: begin
        if (rom_data == 16'hFFFF) begin
          state_nxt_s = ST_FINISH;
        end else if (rom_data[15:8] == 8'hFF) begin
          // Delay pseudo-entry: N ms, with N = 0 treated as a no-op
          if (rom_data[7:0] == 8'h00) begin
            state_nxt_s = ST_NEXT;
          end else begin
            dly_nxt_s   = DW'(rom_data[7:0]) * DW'(MS_CYCLES) - DW'(1);
            state_nxt_s = ST_DELAY;
          end
        end else begin
          sccb_address_nxt_s = rom_data[15:8];
          sccb_data_nxt_s    = rom_data[7:0];
          state_nxt_s        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (sccb_ready) begin
          sccb_start_nxt_s = 1'b1;
          state_nxt_s      = ST_WAIT_LOW;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT_LOW: begin
        if (wd_hit_s) begin
          err_nxt_s   = 1'b1;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (!sccb_ready) begin
          state_nxt_s = ST_WAIT_HIGH;
        end else begin
          state_nxt_s = ST_WAIT_LOW;
        end
      end
      ST_WAIT_HIGH: begin
        if (wd_hit_s) begin
          err_nxt_s   = 1'b1;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (sccb_ready) begin
          state_nxt_s = ST_NEXT;
        end else begin
          state_nxt_s = ST_WAIT_HIGH;
        end
      end
      ST_DELAY: begin
        if (dly_r == {DW{1'b0}}) begin
          state_nxt_s = ST_NEXT;
        end else begin
          dly_nxt_s = dly_r - DW'(1);
        end
      end
      ST_NEXT: begin
        // The last ROM slot is an implicit end of table; the address never wraps
        if (rom_addr_r == ADDR_LAST) begin
          state_nxt_s = ST_FINISH;
        end else begin
          rom_addr_nxt_s = rom_addr_r + {{(ROM_AW-1){1'b0}}, 1'b1};
          state_nxt_s    = ST_FETCH;
        end
      end
      ST_FINISH: begin
        busy_nxt_s  = 1'b0;
        done_nxt_s  = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      rom_addr_r     <= {ROM_AW{1'b0}};
      sccb_start_r   <= 1'b0;
      sccb_address_r <= 8'h00;
      sccb_data_r    <= 8'h00;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      err_r          <= 1'b0;
      dly_r          <= {DW{1'b0}};
    end else begin
      state_r        <= state_nxt_s;
      rom_addr_r     <= rom_addr_nxt_s;
      sccb_start_r   <= sccb_start_nxt_s;
      sccb_address_r <= sccb_address_nxt_s;
      sccb_data_r    <= sccb_data_nxt_s;
      busy_r         <= busy_nxt_s;
      done_r         <= done_nxt_s;
      err_r          <= err_nxt_s;
      dly_r          <= dly_nxt_s;
    end
  end

  assign rom_addr     = rom_addr_r;
  assign sccb_start   = sccb_start_r;
  assign sccb_address = sccb_address_r;
  assign sccb_data    = sccb_data_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Bench for cam_cfg_sequencer: registered ROM model, behavioural SCCB master, table-level reference model.
module tb_cam_cfg_sequencer;

  localparam int CLK_FREQ_TB = 10000;
  localparam int MS          = CLK_FREQ_TB / 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [1:0]  rom_addr;
  logic [15:0] rom_data = 16'h0000;
  logic        sccb_start;
  logic [7:0]  sccb_address;
  logic [7:0]  sccb_data;
  logic        sccb_ready = 1'b1;
  logic        busy, done, err;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] rom [4];
  int          lat [4];
  int          wr_cnt    = 0;
  int          wr_base   = 0;
  int          ready_cnt = 0;
  int          prot_err  = 0;
  logic        prev_start = 1'b0;
  logic        chk_hold   = 1'b1;
  logic [7:0]  held_a = 8'h00, held_d = 8'h00;
  logic [7:0]  cap_a [$];
  logic [7:0]  cap_d [$];

  always #5 clk = ~clk;

  cam_cfg_sequencer #(.CLK_FREQ(CLK_FREQ_TB), .ROM_AW(2), .WD_CYCLES(1000)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_start(sccb_start), .sccb_address(sccb_address), .sccb_data(sccb_data),
    .sccb_ready(sccb_ready), .busy(busy), .done(done), .err(err)
  );

  // Registered ROM: data valid one cycle after the address
  always @(posedge clk) rom_data <= rom[rom_addr];

  // SCCB master model: ready drops after start is sampled, low for lat[k] cycles
  always @(posedge clk) begin
    prev_start <= sccb_start;
    if (sccb_start && (!sccb_ready || prev_start)) prot_err <= prot_err + 1;
    if (sccb_start && sccb_ready) begin
      cap_a.push_back(sccb_address);
      cap_d.push_back(sccb_data);
      held_a     <= sccb_address;
      held_d     <= sccb_data;
      sccb_ready <= 1'b0;
      ready_cnt  <= lat[(wr_cnt - wr_base) % 4];
      wr_cnt     <= wr_cnt + 1;
    end else if (!sccb_ready) begin
      if (chk_hold && (sccb_address != held_a || sccb_data != held_d)) prot_err <= prot_err + 1;
      if (ready_cnt <= 1) sccb_ready <= 1'b1;
      else ready_cnt <= ready_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete walk of the current rom[]/lat[] against the reference model
  task automatic run_walk(input string name, input bit poke, input bit chk_t);
    int t = 0, nw = 0, last = 3, n = 0;
    bit ended = 1'b0;
    logic [7:0] ea [4];
    logic [7:0] ed [4];
    for (int i = 0; i < 4 && !ended; i++) begin
      if (rom[i] == 16'hFFFF) begin
        t += 3; ended = 1'b1; last = i;
      end else if (rom[i][15:8] == 8'hFF) begin
        t += 3 + MS * int'(rom[i][7:0]);
      end else begin
        ea[nw] = rom[i][15:8]; ed[nw] = rom[i][7:0];
        t += lat[nw] + 6; nw++;
      end
    end
    if (!ended) t += 1;

    wr_base = wr_cnt;
    @(negedge clk) cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    chk($sformatf("%s.busy_start", name), {31'd0, busy}, 32'd1);
    chk($sformatf("%s.done_clr", name), {31'd0, done}, 32'd0);
    while (!done && n < 6000) begin
      @(posedge clk); #1;
      n++;
      cfg_start = poke && (n == 1);
    end
    cfg_start = 1'b0;
    if (chk_t) chk($sformatf("%s.cycles", name), n, t);
    chk($sformatf("%s.done", name), {31'd0, done}, 32'd1);
    chk($sformatf("%s.busy", name), {31'd0, busy}, 32'd0);
    chk($sformatf("%s.err", name), {31'd0, err}, 32'd0);
    chk($sformatf("%s.rom_addr", name), {30'd0, rom_addr}, last);
    chk($sformatf("%s.writes", name), wr_cnt - wr_base, nw);
    for (int i = 0; i < nw; i++) begin
      if (wr_base + i < cap_a.size()) begin
        chk($sformatf("%s.addr%0d", name, i), {24'd0, cap_a[wr_base + i]}, {24'd0, ea[i]});
        chk($sformatf("%s.data%0d", name, i), {24'd0, cap_d[wr_base + i]}, {24'd0, ed[i]});
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    cfg_start = 1'b0;
    rom = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    lat = '{5, 5, 5, 5};
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.start", {31'd0, sccb_start}, 32'd0);
    chk("reset.rom_addr", {30'd0, rom_addr}, 32'd0);
    rst = 1'b0;

    rom = '{16'h1280, 16'h1100, 16'hFFFF, 16'h5555};
    lat = '{50, 50, 50, 50};
    run_walk("two_writes", 1'b0, 1'b1);
    rom = '{16'hFF03, 16'h3A04, 16'hFFFF, 16'h0000};
    lat = '{4, 4, 4, 4};
    run_walk("delay3", 1'b0, 1'b1);
    rom = '{16'hFFFF, 16'h0101, 16'h0202, 16'h0303};
    run_walk("empty", 1'b1, 1'b1);
    rom = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
    lat = '{3, 7, 1, 2};
    run_walk("no_end", 1'b0, 1'b1);
    rom = '{16'hFF00, 16'hFFFE, 16'h7788, 16'hFF00};
    run_walk("delay_bounds", 1'b1, 1'b1);

    for (int w = 0; w < 30; w++) begin
      for (int i = 0; i < 4; i++) begin
        k = $urandom_range(0, 9);
        if (k == 0) rom[i] = 16'hFFFF;
        else if (k <= 3) rom[i] = {8'hFF, 8'($urandom_range(0, 6))};
        else rom[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
        lat[i] = $urandom_range(1, 20);
      end
      run_walk($sformatf("rand%0d", w), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset during the second transaction, then restart while the master is still busy
    rom = '{16'h1111, 16'h2222, 16'h3333, 16'hFFFF};
    lat = '{3, 40, 3, 3};
    wr_base = wr_cnt;
    @(negedge clk) cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    k = 0;
    while ((wr_cnt - wr_base) < 2 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rst_mid.reached", wr_cnt - wr_base, 2);
    repeat (20) @(posedge clk);
    chk_hold = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_mid.ready_low", {31'd0, sccb_ready}, 32'd0);
    chk("rst_mid.busy", {31'd0, busy}, 32'd0);
    chk("rst_mid.done", {31'd0, done}, 32'd0);
    chk("rst_mid.err", {31'd0, err}, 32'd0);
    chk("rst_mid.start", {31'd0, sccb_start}, 32'd0);
    chk("rst_mid.addr", {24'd0, sccb_address}, 32'd0);
    chk("rst_mid.data", {24'd0, sccb_data}, 32'd0);
    chk("rst_mid.rom_addr", {30'd0, rom_addr}, 32'd0);
    lat = '{3, 3, 3, 3};
    run_walk("restart", 1'b0, 1'b0);
    chk_hold = 1'b1;

    chk("protocol", prot_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
